// File: rtl/upg_pkg.sv
// Shared types and constants for the UART upgrade loader (state encoding, frame geometry).
package upg_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } upg_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/upg_word_packer.sv
// Collects four received bytes little-endian into a 32-bit word and pulses word_valid_o
// one cycle after the fourth byte; the word output holds until the next completed word.
module upg_word_packer
  import upg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_lane_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  lane_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;
  logic        word_valid_q;

  assign last_lane_o = (lane_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q       <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_valid_i && last_lane_o;
      if (byte_valid_i) begin
        lane_q <= lane_q + 2'd1;
        // Earlier bytes shift down so byte 0 ends up in bits [7:0].
        if (last_lane_o) begin
          word_q <= {byte_i, shift_q};
        end else begin
          shift_q <= {byte_i, shift_q[23:8]};
        end
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/upg_uart_loader.sv
// Parses one download frame (LE word count, LE data words) into program-memory writes.
// Define UPG_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module upg_uart_loader
  import upg_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int     TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int     WIDX_W = ADDR_W + 1;
  localparam longint MAX_N  = longint'(1) << ADDR_W;
`ifdef UPG_CHECKSUM_EN
  localparam upg_state_e POST_DATA = CSUM;
`else
  localparam upg_state_e POST_DATA = DONE;
`endif

  upg_state_e        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  logic        active;
  logic        tmo_hit;
  logic        last_lane;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] hdr_n;

  assign active  = (state_q == HDR1) || (state_q == DATA) || (state_q == CSUM);
  assign tmo_hit = active && !rx_valid_i && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign hdr_n   = {rx_byte_i, count_q[7:0]};

  upg_word_packer u_packer (
    .clk_i        (upg_clk_i),
    .rst_i        (upg_rst_i),
    .byte_valid_i (rx_valid_i && (state_q == DATA)),
    .byte_i       (rx_byte_i),
    .last_lane_o  (last_lane),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    adr_d   = adr_q;
`ifdef UPG_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    if (rx_valid_i || !active) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      HDR0: begin
        if (rx_valid_i) begin
          count_d[7:0] = rx_byte_i;
          state_d      = HDR1;
        end
      end
      HDR1: begin
        if (rx_valid_i) begin
          count_d[15:8] = rx_byte_i;
          if (longint'(hdr_n) > MAX_N) begin
            state_d = ERR;
          end else if (hdr_n == 16'd0) begin
            state_d = POST_DATA;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid_i) begin
`ifdef UPG_CHECKSUM_EN
          acc_d = acc_q ^ rx_byte_i;
`endif
          // Leave DATA on the last byte itself so a back-to-back checksum byte is not lost.
          if (last_lane) begin
            adr_d  = widx_q[ADDR_W-1:0];
            widx_d = widx_q + WIDX_W'(1);
            if (32'(widx_q) + 32'd1 == 32'(count_q)) begin
              state_d = POST_DATA;
            end
          end
        end
      end
`ifdef UPG_CHECKSUM_EN
      CSUM: begin
        if (rx_valid_i) begin
          state_d = (rx_byte_i == acc_q) ? DONE : ERR;
        end
      end
`endif
      default: begin
      end
    endcase

    if (tmo_hit) begin
      state_d = ERR;
    end
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q <= HDR0;
      count_q <= '0;
      widx_q  <= '0;
      adr_q   <= '0;
      tmo_q   <= '0;
`ifdef UPG_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      adr_q   <= adr_d;
      tmo_q   <= tmo_d;
`ifdef UPG_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign upg_wen_o  = word_valid;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = word;
  assign upg_done_o = (state_q == DONE);
  assign upg_err_o  = (state_q == ERR);

endmodule

// File: tb/tb_upg_uart_loader.sv
// Directed bench for upg_uart_loader; follows UPG_CHECKSUM_EN to append checksum bytes.
module tb_upg_uart_loader;

  localparam int ADDR_W = 14;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              wen;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;
  int wen_cnt = 0;
  int base;

  upg_uart_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .rx_valid_i (rx_valid),
    .rx_byte_i  (rx_byte),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  always #5 clk = ~clk;

  // Counts the strobe of the cycle just ending (sampled before this edge's updates).
  always @(posedge clk) if (wen === 1'b1) wen_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_adr", 32'(adr), 32'd0);
    chk("rst_dat", dat, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle(100);
    chk("hdr0_no_timeout", 32'(err), 32'd0);

    // N=2 frame, back-to-back bytes
    base = wen_cnt;
    put(8'h02); put(8'h00);
    put(8'h78); put(8'h56); put(8'h34); put(8'h12);
    chk("w0_wen", 32'(wen), 32'd1);
    chk("w0_adr", 32'(adr), 32'd0);
    chk("w0_dat", dat, 32'h12345678);
    put(8'hEF);
    chk("w0_wen_one_cycle", 32'(wen), 32'd0);
    chk("w0_dat_hold", dat, 32'h12345678);
    put(8'hBE); put(8'hAD); put(8'hDE);
    chk("w1_wen", 32'(wen), 32'd1);
    chk("w1_adr", 32'(adr), 32'd1);
    chk("w1_dat", dat, 32'hDEADBEEF);
`ifdef UPG_CHECKSUM_EN
    put(8'h2A);
`endif
    idle(3);
    chk("f1_done", 32'(done), 32'd1);
    chk("f1_err", 32'(err), 32'd0);
    chk("f1_wen_count", 32'(wen_cnt - base), 32'd2);
    put(8'h55); put(8'h55); put(8'h55); put(8'h55);
    idle(3);
    chk("f1_ignore_after_done", 32'(wen_cnt - base), 32'd2);
    chk("f1_done_hold", 32'(done), 32'd1);
    chk("f1_adr_hold", 32'(adr), 32'd1);

    // N=0
    do_reset();
    base = wen_cnt;
    put(8'h00); put(8'h00);
`ifdef UPG_CHECKSUM_EN
    put(8'h00);
`endif
    idle(3);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_err", 32'(err), 32'd0);
    chk("n0_no_wen", 32'(wen_cnt - base), 32'd0);

    // N=16385 rejected
    do_reset();
    base = wen_cnt;
    put(8'h01); put(8'h40);
    idle(2);
    chk("ovr_err", 32'(err), 32'd1);
    chk("ovr_done", 32'(done), 32'd0);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    idle(3);
    chk("ovr_no_wen", 32'(wen_cnt - base), 32'd0);
    chk("ovr_err_hold", 32'(err), 32'd1);

    // N=16384 accepted
    do_reset();
    put(8'h00); put(8'h40);
    idle(10);
    chk("max_err", 32'(err), 32'd0);
    chk("max_done", 32'(done), 32'd0);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    chk("max_wen", 32'(wen), 32'd1);
    chk("max_adr", 32'(adr), 32'd0);
    chk("max_dat", dat, 32'h44332211);

    // Timeout after 2 data bytes
    do_reset();
    base = wen_cnt;
    put(8'h01); put(8'h00); put(8'hAA); put(8'hBB);
    idle(TMO - 4);
    chk("tmo_not_yet", 32'(err), 32'd0);
    idle(8);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_done", 32'(done), 32'd0);
    chk("tmo_no_wen", 32'(wen_cnt - base), 32'd0);

`ifdef UPG_CHECKSUM_EN
    // Bad then good checksum, N=1
    do_reset();
    base = wen_cnt;
    put(8'h01); put(8'h00); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    put(8'h05);
    idle(2);
    chk("cs_bad_err", 32'(err), 32'd1);
    chk("cs_bad_done", 32'(done), 32'd0);
    chk("cs_bad_wen", 32'(wen_cnt - base), 32'd1);
    do_reset();
    put(8'h01); put(8'h00); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    put(8'h04);
    idle(2);
    chk("cs_good_done", 32'(done), 32'd1);
    chk("cs_good_err", 32'(err), 32'd0);
`endif

    // Reset mid-word, then a fresh N=1 frame
    do_reset();
    base = wen_cnt;
    put(8'h01); put(8'h00); put(8'h11); put(8'h22); put(8'h33);
    do_reset();
    put(8'h01); put(8'h00); put(8'hA1); put(8'hB2); put(8'hC3); put(8'hD4);
    chk("mid_wen", 32'(wen), 32'd1);
    chk("mid_adr", 32'(adr), 32'd0);
    chk("mid_dat", dat, 32'hD4C3B2A1);
`ifdef UPG_CHECKSUM_EN
    put(8'h04);
`endif
    idle(3);
    chk("mid_wen_count", 32'(wen_cnt - base), 32'd1);
    chk("mid_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
